sub_serial_seq: RTL and testbench

//  Upstream sequencer for the 4-bit borrow subtraction stage.
//  - Accepts two wide operands and streams them, least-significant nibble first, into the stage.
//  - Chains the stage's borrow-out back into its borrow-in on the next cycle.
//  - Assembles the full-width difference, final borrow and signed overflow.
//  - Lets one 4-bit subtractor serve 8/16/32-bit datapaths.

---
 rtl/sub_serial_seq.sv | 174 +++++++++++++++++
 tb/tb_sub_serial_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_seq.sv
// -----------------------------------------------------------------------------
// sub_serial_seq
//
// Purpose:
//   Upstream sequencer for an external 4-bit borrow subtraction stage. It
//   latches two W-bit operands (W = 4*NIBBLES) and feeds them to the stage one
//   nibble per cycle, least-significant first. The stage's borrow-out is
//   registered and returned as the next nibble's borrow-in. When the last
//   nibble has been processed, the full difference, final borrow and signed
//   overflow are published together.
//
// Parameters:
//   NIBBLES      operand width in nibbles, legal 2..8
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous reset, active low (aborts any running operation)
//   start        request, sampled only while idle
//   OpA, OpB     minuend / subtrahend, latched when start is accepted
//   BorrowInit   borrow into nibble 0, latched when start is accepted
//   SubA, SubB   current latched nibble to the stage (0 when not running)
//   SubBorrowIN  borrow register to the stage (0 when not running)
//   SubY         stage difference nibble (combinational, same cycle)
//   SubBorrowOUT stage borrow-out (combinational, same cycle)
//   busy         high while nibbles are being streamed
//   done         one-cycle completion pulse
//   Result       A - B - BorrowInit mod 2^W (or saturated, see below)
//   BorrowOUT    borrow out of the top nibble
//   Overflow     two's-complement overflow of the W-bit subtraction
//
// Configuration macro:
//   SUB_SAT_EN   when defined, Result saturates to the most positive value
//                (A non-negative) or most negative value (A negative) on
//                overflow. Overflow and BorrowOUT are reported unchanged.
// -----------------------------------------------------------------------------
module sub_serial_seq #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] OpA,
    input  logic [W-1:0] OpB,
    input  logic         BorrowInit,
    output logic [3:0]   SubA,
    output logic [3:0]   SubB,
    output logic         SubBorrowIN,
    input  logic [3:0]   SubY,
    input  logic         SubBorrowOUT,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Result,
    output logic         BorrowOUT,
    output logic         Overflow
);

    localparam int             IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [NIBBLES-1:0][3:0]    r_a;
    logic [NIBBLES-1:0][3:0]    r_b;
    // Only the lower NIBBLES-1 nibbles need storage: the top nibble is merged
    // straight from SubY on the final cycle.
    logic [NIBBLES-2:0][3:0]    r_shadow;
    logic [IW-1:0]              r_idx;
    logic                       r_borrow;
    logic                       r_busy;
    logic                       r_done;
    logic [W-1:0]               r_result;
    logic                       r_borrow_out;
    logic                       r_overflow;

    logic [W-1:0]               w_diff;
    logic [W-1:0]               w_result;
    logic                       w_a_msb;
    logic                       w_b_msb;
    logic                       w_ovf;

    // Full difference as it will look once the final nibble lands.
    assign w_diff  = {SubY, r_shadow};
    assign w_a_msb = r_a[NIBBLES-1][3];
    assign w_b_msb = r_b[NIBBLES-1][3];
    // Signs differ and the result sign departs from the minuend sign.
    assign w_ovf   = (w_a_msb != w_b_msb) && (w_diff[W-1] != w_a_msb);

    // Final result selection: wrapped difference or saturated value.
    always_comb begin
        w_result = w_diff;
`ifdef SUB_SAT_EN
        if (w_ovf) begin
            w_result = w_a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            w_result = w_diff;
        end
`endif
    end

    // Sequencer FSM with all datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_shadow     <= '0;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= OpA;
                        r_b      <= OpB;
                        r_borrow <= BorrowInit;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_borrow <= SubBorrowOUT;
                    if (r_idx == LAST_IDX) begin
                        // Publish everything at once so no partial sum is visible.
                        r_result     <= w_result;
                        r_borrow_out <= SubBorrowOUT;
                        r_overflow   <= w_ovf;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_shadow[r_idx] <= SubY;
                        r_idx           <= r_idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage inputs come only from latched registers and are zero when idle.
    assign SubA        = r_busy ? r_a[r_idx] : 4'h0;
    assign SubB        = r_busy ? r_b[r_idx] : 4'h0;
    assign SubBorrowIN = r_busy ? r_borrow   : 1'b0;

    assign busy      = r_busy;
    assign done      = r_done;
    assign Result    = r_result;
    assign BorrowOUT = r_borrow_out;
    assign Overflow  = r_overflow;

endmodule

// File: tb/tb_sub_serial_seq.sv
module tb_sub_serial_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic         BorrowInit;
    logic [3:0]   SubA;
    logic [3:0]   SubB;
    logic         SubBorrowIN;
    logic [3:0]   SubY;
    logic         SubBorrowOUT;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         BorrowOUT;
    logic         Overflow;

    int n_tests = 0;
    int n_fail  = 0;

    sub_serial_seq #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .OpA(OpA), .OpB(OpB),
        .BorrowInit(BorrowInit), .SubA(SubA), .SubB(SubB),
        .SubBorrowIN(SubBorrowIN), .SubY(SubY), .SubBorrowOUT(SubBorrowOUT),
        .busy(busy), .done(done), .Result(Result), .BorrowOUT(BorrowOUT),
        .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit borrow subtractor stage.
    logic [4:0] stage_d;
    assign stage_d      = {1'b0, SubA} - {1'b0, SubB} - 5'(SubBorrowIN);
    assign SubY         = stage_d[3:0];
    assign SubBorrowOUT = stage_d[4];

    // Reference: {Overflow, BorrowOUT, Result} from whole-word arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        longint       d;
        logic [W-1:0] r;
        logic         bo;
        logic         ov;
        d  = longint'(a) - longint'(b) - longint'(bin);
        bo = (d < 0);
        r  = d[W-1:0];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
`ifdef SUB_SAT_EN
        if (ov) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {ov, bo, r};
    endfunction

    // Expected borrow into each nibble: bit i set when the low 4*i bits borrow.
    function automatic int exp_sbin(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int     m;
        longint mk;
        m = 0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (i == 0) begin
                m = m | int'(bin);
            end else begin
                mk = (longint'(1) << (4 * i)) - 1;
                if (((longint'(a) & mk) - (longint'(b) & mk) - longint'(bin)) < 0) m = m | (1 << i);
            end
        end
        return m;
    endfunction

    // Launch one operation and record what the DUT shows in the following cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input logic poke,
                          output logic [W-1:0] res, output logic bo, output logic ov,
                          output int busy_mask, output int done_mask, output int sbin_mask,
                          output logic [W-1:0] sa_tr, output logic [W-1:0] sb_tr,
                          output logic idle_clean, output logic held);
        logic [W-1:0] prev_r;
        logic         prev_bo;
        logic         prev_ov;
        @(negedge clk);
        prev_r = Result; prev_bo = BorrowOUT; prev_ov = Overflow;
        OpA = a; OpB = b; BorrowInit = bin; start = 1'b1;
        busy_mask = 0; done_mask = 0; sbin_mask = 0;
        sa_tr = '0; sb_tr = '0; idle_clean = 1'b1; held = 1'b1;
        res = '0; bo = 1'b0; ov = 1'b0;
        for (int c = 0; c <= NIBBLES + 2; c++) begin
            @(negedge clk);
            if (busy) busy_mask = busy_mask | (1 << c);
            if (done) done_mask = done_mask | (1 << c);
            if (SubBorrowIN) sbin_mask = sbin_mask | (1 << c);
            if (c < NIBBLES) begin
                sa_tr[4*c +: 4] = SubA;
                sb_tr[4*c +: 4] = SubB;
                if (Result !== prev_r || BorrowOUT !== prev_bo || Overflow !== prev_ov) held = 1'b0;
            end else if (c == NIBBLES) begin
                idle_clean = (SubA == 4'h0) && (SubB == 4'h0) && (SubBorrowIN == 1'b0);
                res = Result; bo = BorrowOUT; ov = Overflow;
            end else begin
                if (Result !== res || BorrowOUT !== bo || Overflow !== ov) held = 1'b0;
            end
            // Operands may change freely once accepted.
            OpA = W'($urandom); OpB = W'($urandom); BorrowInit = 1'($urandom);
            start = (poke && (c == 1 || c == NIBBLES)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; OpA = '0; OpB = '0; BorrowInit = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
        end
        n_tests++;
        if (Result !== '0 || BorrowOUT !== 1'b0 || Overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs: Result=%h Bo=%b Ov=%b, required 0", Result, BorrowOUT, Overflow);
        end
        n_tests++;
        if (SubA !== 4'h0 || SubB !== 4'h0 || SubBorrowIN !== 1'b0) begin
            n_fail++; $display("FAIL reset_stage: SubA=%h SubB=%h SubBin=%b, required 0", SubA, SubB, SubBorrowIN);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         tbin [5];
        logic [W-1:0] tr [5];
        logic         tbo [5];
        logic         tov [5];
        logic [W-1:0] res, sa, sb;
        logic         bo, ov, idle_clean, held;
        int           bm, dm, sm;
        ta[0] = 16'h0006; tb[0] = 16'h0002; tbin[0] = 1'b0; tr[0] = 16'h0004; tbo[0] = 1'b0; tov[0] = 1'b0;
        ta[1] = 16'h0002; tb[1] = 16'h0006; tbin[1] = 1'b0; tr[1] = 16'hFFFC; tbo[1] = 1'b1; tov[1] = 1'b0;
`ifdef SUB_SAT_EN
        ta[2] = 16'h8000; tb[2] = 16'h0001; tbin[2] = 1'b0; tr[2] = 16'h8000; tbo[2] = 1'b0; tov[2] = 1'b1;
`else
        ta[2] = 16'h8000; tb[2] = 16'h0001; tbin[2] = 1'b0; tr[2] = 16'h7FFF; tbo[2] = 1'b0; tov[2] = 1'b1;
`endif
        ta[3] = 16'hFFFF; tb[3] = 16'h0001; tbin[3] = 1'b1; tr[3] = 16'hFFFD; tbo[3] = 1'b0; tov[3] = 1'b0;
        ta[4] = 16'h5A5A; tb[4] = 16'h5A5A; tbin[4] = 1'b1; tr[4] = 16'hFFFF; tbo[4] = 1'b1; tov[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tbin[i], 1'b0, res, bo, ov, bm, dm, sm, sa, sb, idle_clean, held);
            n_tests++;
            if (res !== tr[i] || bo !== tbo[i] || ov !== tov[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: got R=%h Bo=%b Ov=%b, required R=%h Bo=%b Ov=%b",
                         i, res, bo, ov, tr[i], tbo[i], tov[i]);
            end
            n_tests++;
            if (bm !== 32'h0000_000F || dm !== 32'h0000_0010) begin
                n_fail++; $display("FAIL dir%0d_timing: busy=%h done=%h, required 0f 10", i, bm, dm);
            end
            if (i == 3) begin
                n_tests++;
                if (sm !== 1) begin
                    n_fail++; $display("FAIL dir3_subbin: mask=%h, required 1", sm);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, res, sa, sb;
        logic         bin, bo, ov, idle_clean, held;
        logic [W+1:0] e;
        int           bm, dm, sm, es;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = '0;
                1: a = '1;
                2: a = {1'b1, {(W-1){1'b0}}};
                3: a = {1'b0, {(W-1){1'b1}}};
                default: a = W'($urandom);
            endcase
            b   = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            bin = 1'($urandom);
            e   = model(a, b, bin);
            es  = exp_sbin(a, b, bin);
            run_op(a, b, bin, 1'b0, res, bo, ov, bm, dm, sm, sa, sb, idle_clean, held);
            n_tests++;
            if (res !== e[W-1:0] || bo !== e[W] || ov !== e[W+1]) begin
                n_fail++;
                $display("FAIL rnd%0d_result: A=%h B=%h Bin=%b got R=%h Bo=%b Ov=%b, required R=%h Bo=%b Ov=%b",
                         i, a, b, bin, res, bo, ov, e[W-1:0], e[W], e[W+1]);
            end
            n_tests++;
            if (bm !== 32'h0000_000F || dm !== 32'h0000_0010) begin
                n_fail++; $display("FAIL rnd%0d_timing: busy=%h done=%h, required 0f 10", i, bm, dm);
            end
            n_tests++;
            if (sm !== es) begin
                n_fail++; $display("FAIL rnd%0d_subbin: mask=%h, required %h", i, sm, es);
            end
            n_tests++;
            if (sa !== a || sb !== b) begin
                n_fail++; $display("FAIL rnd%0d_nibbles: SubA=%h SubB=%h, required %h %h", i, sa, sb, a, b);
            end
            n_tests++;
            if (idle_clean !== 1'b1 || held !== 1'b1) begin
                n_fail++; $display("FAIL rnd%0d_hold: idle_clean=%b held=%b, required 1 1", i, idle_clean, held);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] res, sa, sb;
        logic         bo, ov, idle_clean, held;
        int           bm, dm, sm;
        run_op(16'h1357, 16'h2468, 1'b0, 1'b1, res, bo, ov, bm, dm, sm, sa, sb, idle_clean, held);
        n_tests++;
        if (res !== 16'hEEEF || bo !== 1'b1 || ov !== 1'b0) begin
            n_fail++; $display("FAIL ignore_result: got R=%h Bo=%b Ov=%b, required R=eeef Bo=1 Ov=0", res, bo, ov);
        end
        n_tests++;
        if (dm !== 32'h0000_0010 || bm !== 32'h0000_000F) begin
            n_fail++; $display("FAIL ignore_done: busy=%h done=%h, required 0f 10", bm, dm);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] res, sa, sb;
        logic         bo, ov, idle_clean, held;
        int           bm, dm, sm, dcount;
        run_op(16'h0002, 16'h0006, 1'b0, 1'b0, res, bo, ov, bm, dm, sm, sa, sb, idle_clean, held);
        @(negedge clk);
        OpA = 16'h4444; OpB = 16'h1111; BorrowInit = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || Result !== '0 || BorrowOUT !== 1'b0 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outs: busy=%b done=%b R=%h Bo=%b Ov=%b, required all 0",
                     busy, done, Result, BorrowOUT, Overflow);
        end
        n_tests++;
        if (SubA !== 4'h0 || SubB !== 4'h0 || SubBorrowIN !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stage: SubA=%h SubB=%h Bin=%b, required 0", SubA, SubB, SubBorrowIN);
        end
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        n_tests++;
        if (dcount !== 0) begin
            n_fail++; $display("FAIL midrst_nodone: %0d active cycles, required 0", dcount);
        end
        run_op(16'h1234, 16'h0234, 1'b0, 1'b0, res, bo, ov, bm, dm, sm, sa, sb, idle_clean, held);
        n_tests++;
        if (res !== 16'h1000 || bo !== 1'b0 || ov !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after: got R=%h Bo=%b Ov=%b, required R=1000 Bo=0 Ov=0", res, bo, ov);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W+1:0] e1;
        logic [W+1:0] e2;
        int           dm;
        e1 = model(16'hA000, 16'h0FFF, 1'b0);
        e2 = model(16'h0123, 16'h0456, 1'b1);
        r1 = '0; r2 = '0; dm = 0;
        @(negedge clk);
        OpA = 16'hA000; OpB = 16'h0FFF; BorrowInit = 1'b0; start = 1'b1;
        for (int c = 0; c <= 2 * NIBBLES + 4; c++) begin
            @(negedge clk);
            if (done) dm = dm | (1 << c);
            if (c == NIBBLES) r1 = Result;
            if (c == 2 * NIBBLES + 2) r2 = Result;
            if (c == 1) begin
                OpA = 16'h0123; OpB = 16'h0456; BorrowInit = 1'b1;
            end
            if (c == NIBBLES + 2) start = 1'b0;
        end
        n_tests++;
        if (dm !== ((1 << NIBBLES) | (1 << (2 * NIBBLES + 2)))) begin
            n_fail++; $display("FAIL b2b_done: mask=%h, required %h", dm, (1 << NIBBLES) | (1 << (2 * NIBBLES + 2)));
        end
        n_tests++;
        if (r1 !== e1[W-1:0] || r2 !== e2[W-1:0]) begin
            n_fail++; $display("FAIL b2b_results: got %h %h, required %h %h", r1, r2, e1[W-1:0], e2[W-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
